// File: rtl/nbody_pkg.sv
// Shared defaults and controller state encoding for the n-body timestep sequencer.
package nbody_pkg;

  localparam int BODIES_DEF = 512;
  localparam int IDX_W_DEF  = $clog2(BODIES_DEF);
  localparam int STEP_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_ACC_WAIT,
    S_LEAP,
    S_LF_WAIT,
    S_STEP,
    S_FIN
  } ctrl_state_t;

endpackage

// File: rtl/nbody_pair_gen.sv
// Walks (i, j) over all ordered body pairs with j != i; advances once per accepted transfer.
module nbody_pair_gen
  import nbody_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W:0]   n,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last,
  output logic             pair_final
);

  localparam logic [IDX_W:0]   N_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   N_TWO   = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);

  logic [IDX_W:0]   n_m1;
  logic [IDX_W:0]   n_m2;
  logic             last_i;
  logic [IDX_W-1:0] j_inc;

  assign n_m1   = n - N_ONE;
  assign n_m2   = n - N_TWO;
  assign last_i = ({1'b0, i} == n_m1);
  // The last target body has no j = N-1 partner after skipping itself, so it ends one early.
  assign last       = last_i ? ({1'b0, j} == n_m2) : ({1'b0, j} == n_m1);
  assign pair_final = last_i & last;
  assign j_inc      = j + IDX_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
    end else if (clear) begin
      i <= '0;
      j <= IDX_ONE;
    end else if (advance) begin
      if (last) begin
        if (!last_i) begin
          i <= i + IDX_ONE;
          j <= '0;
        end
      end else if (j_inc == i) begin
        j <= j + IDX_TWO;
      end else begin
        j <= j_inc;
      end
    end
  end

endmodule

// File: rtl/nbody_step_ctrl.sv
// Timestep sequencer: issues all acceleration pairs, waits for completions, then leapfrog updates.
//   state    | meaning
//   IDLE     | waiting for start
//   ACCEL    | issuing (i, j) pairs to the acceleration unit
//   ACC_WAIT | waiting for N acc_done pulses
//   LEAP     | issuing body indices to the leapfrog unit
//   LF_WAIT  | waiting for N lf_done pulses
//   STEP     | bump step_count, loop or finish
//   FIN      | one-cycle done pulse
module nbody_step_ctrl
  import nbody_pkg::*;
#(
  parameter int BODIES = BODIES_DEF,
  parameter int IDX_W  = $clog2(BODIES),
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W:0]    num_bodies,
  input  logic [STEP_W-1:0] n_steps,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [IDX_W-1:0]  acc_i,
  output logic [IDX_W-1:0]  acc_j,
  output logic              acc_last,
  input  logic              acc_done,
  output logic              lf_valid,
  input  logic              lf_ready,
  output logic [IDX_W-1:0]  lf_idx,
  input  logic              lf_done
);

  localparam logic [IDX_W:0]    N_ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]    N_TWO    = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [IDX_W:0]    n_q;
  logic [STEP_W-1:0] steps_q;
  logic [IDX_W:0]    acc_rem;
  logic [IDX_W:0]    lf_rem;
  logic [STEP_W-1:0] step_inc;
  logic              start_ok;
  logic              acc_xfer;
  logic              lf_xfer;
  logic              lf_last;
  logic              pg_clear;
  logic              pg_last;
  logic              pg_final;

  assign acc_valid = (state == S_ACCEL);
  assign lf_valid  = (state == S_LEAP);
  assign done      = (state == S_FIN);
  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign acc_last  = acc_valid & pg_last;

  assign acc_xfer = acc_valid & acc_ready;
  assign lf_xfer  = lf_valid & lf_ready;
  assign lf_last  = ({1'b0, lf_idx} == (n_q - N_ONE));
  assign step_inc = step_count + STEP_ONE;
  assign start_ok = (num_bodies >= N_TWO) && (n_steps != '0);

  nbody_pair_gen #(
    .IDX_W(IDX_W)
  ) u_pair_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (pg_clear),
    .advance   (acc_xfer),
    .n         (n_q),
    .i         (acc_i),
    .j         (acc_j),
    .last      (pg_last),
    .pair_final(pg_final)
  );

  always_comb begin
    state_next = state;
    pg_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = start_ok ? S_ACCEL : S_FIN;
          pg_clear   = 1'b1;
        end
      end
      // Abort drops valid next cycle; a transfer already accepted this cycle still counts.
      S_ACCEL: begin
        if (abort)                    state_next = S_FIN;
        else if (acc_xfer && pg_final) state_next = S_ACC_WAIT;
      end
      S_ACC_WAIT: begin
        if (abort)              state_next = S_FIN;
        else if (acc_rem == '0) state_next = S_LEAP;
      end
      S_LEAP: begin
        if (abort)                  state_next = S_FIN;
        else if (lf_xfer && lf_last) state_next = S_LF_WAIT;
      end
      S_LF_WAIT: begin
        if (abort)             state_next = S_FIN;
        else if (lf_rem == '0) state_next = S_STEP;
      end
      S_STEP: begin
        pg_clear   = 1'b1;
        state_next = (step_inc == steps_q) ? S_FIN : S_ACCEL;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      n_q        <= '0;
      steps_q    <= '0;
      step_count <= '0;
      lf_idx     <= '0;
      acc_rem    <= '0;
      lf_rem     <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        n_q        <= num_bodies;
        steps_q    <= n_steps;
        step_count <= '0;
        lf_idx     <= '0;
        acc_rem    <= start_ok ? num_bodies : '0;
        lf_rem     <= start_ok ? num_bodies : '0;
      end else if (state == S_STEP) begin
        step_count <= step_inc;
        lf_idx     <= '0;
        acc_rem    <= n_q;
        lf_rem     <= n_q;
      end else begin
        if (lf_xfer && !lf_last) lf_idx <= lf_idx + IDX_ONE;
        // Remaining-completion down-counters stop at zero, so surplus pulses are dropped.
        if (busy && acc_done && acc_rem != '0) acc_rem <= acc_rem - N_ONE;
        if (busy && lf_done && lf_rem != '0)   lf_rem  <= lf_rem - N_ONE;
      end
    end
  end

endmodule

// File: doc/nbody_step_ctrl.md
NBODY_STEP_CTRL -- requirements
Module: nbody_step_ctrl

Interface
REQ-001 Parameter: BODIES, default 512, maximum body count supported.
REQ-002 Parameter: IDX_W, default $clog2(BODIES), width of a body index.
REQ-003 Parameter: STEP_W, default 32, width of the timestep counter.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-006 start  in  1  one-cycle request to run a simulation; sampled only in IDLE.
REQ-007 abort  in  1  stop at next handshake boundary; return to IDLE.
REQ-008 num_bodies  in  IDX_W+1  active body count N, latched on accepted start.
REQ-009 n_steps  in  STEP_W  timesteps to run, latched on accepted start.
REQ-010 busy  out  1  high from cycle after accepted start until done.
REQ-011 done  out  1  one-cycle pulse when run completes or is aborted.
REQ-012 step_count  out  STEP_W  completed timesteps of current/last run.
REQ-013 acc_valid / acc_ready  out / in  1 / 1  pair-issue handshake to acceleration unit.
REQ-014 acc_i, acc_j  out  IDX_W each  target body and source body of issued pair.
REQ-015 acc_last  out  1  marks final pair for current acc_i.
REQ-016 acc_done  in  1  pulse: acceleration unit finished one body.
REQ-017 lf_valid / lf_ready  out / in  1 / 1  leapfrog-issue handshake; lf_idx out IDX_W body index.
REQ-018 lf_done  in  1  pulse: leapfrog unit finished one body.

Function
REQ-019 States: IDLE, ACCEL, ACC_WAIT, LEAP, LF_WAIT, STEP, FIN.
REQ-020 IDLE: start=1 with N>=2 and n_steps>0 -> ACCEL next cycle; busy=1, step_count=0, i=0, j=1.
REQ-021 IDLE: start=1 with N<2 or n_steps=0 -> FIN directly (done pulse, no acc/lf traffic).
REQ-022 ACCEL: acc_valid=1; pair transfers when acc_valid&acc_ready; outputs held stable until transfer.
REQ-023 Pair order: i ascending 0..N-1; per i, j ascending 0..N-1 skipping j==i.
REQ-024 acc_last=1 exactly when j is the final non-i index (j=N-1, or N-2 when i=N-1).
REQ-025 After transfer of pair (N-1,N-2) -> ACC_WAIT; acc_valid low.
REQ-026 ACC_WAIT: count acc_done pulses (counted in any state while busy); leave when count reaches N -> LEAP.
REQ-027 LEAP: lf_valid=1, lf_idx 0..N-1 one per lf_valid&lf_ready; after idx N-1 transfers -> LF_WAIT.
REQ-028 LF_WAIT: count lf_done pulses; at N -> STEP.
REQ-029 STEP: step_count+1; if new value == n_steps -> FIN, else ACCEL with i=0, j=1, counters cleared.
REQ-030 FIN: done=1 for one cycle, busy=0 in FIN, -> IDLE; step_count held until next accepted start.
REQ-031 abort in ACCEL/LEAP: no further valid raised after current cycle; a valid already high with ready high completes; -> FIN.
REQ-032 abort in ACC_WAIT/LF_WAIT -> FIN next cycle; abort in IDLE ignored; abort and start same IDLE cycle: start wins.
REQ-033 start while busy ignored; num_bodies/n_steps changes during run ignored.
REQ-034 acc_done/lf_done counters saturate at N; extra pulses ignored.
REQ-035 No combinational path from acc_ready/lf_ready to acc_valid/lf_valid.

Reset
REQ-036 rst=0 at any rising edge: state IDLE, busy=0, done=0, acc_valid=0, lf_valid=0, acc_last=0, acc_i/acc_j/lf_idx=0, step_count=0, all counters 0.
REQ-037 Reset mid-run discards progress; no done pulse generated.

Structure
REQ-038 Package nbody_pkg holds BODIES, IDX_W, STEP_W defaults and the controller state enum.
REQ-039 Sub-module nbody_pair_gen: i/j index counter with skip-self and last-pair flag, advance-on-transfer input.

Verification
REQ-040 N=3, n_steps=1, ready tied high -> pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1), acc_last on (0,2)(1,2)(2,1); after 3 acc_done, lf_idx 0,1,2; done pulse; step_count=1.
REQ-041 N=4, n_steps=3, acc_ready toggling 1/0 -> 12 pairs per step, operands stable while stalled, step_count reaches 3, exactly one done.
REQ-042 start with N=1 or n_steps=0 -> done pulse within 2 cycles, acc_valid and lf_valid never high.
REQ-043 abort during ACCEL after 2 transfers (N=3) -> no third pair, done pulse, busy low, step_count=0.
REQ-044 rst=0 during LEAP -> all outputs at reset values next cycle; subsequent start runs normally from pair (0,1).
REQ-045 start pulsed while busy, N changed mid-run -> no restart; pair count per step matches latched N.
